// File: rtl/systolic_output_drain.sv
// rtl/systolic_output_drain.sv - double-buffered row drain for the systolic array results (optional clamp: SYSTOLIC_DRAIN_RELU_EN)
module systolic_output_drain #(
  parameter int N         = 8,
  parameter int ROW_IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      capture,
  input  logic [N-1:0][N-1:0][31:0] C_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N-1:0][31:0]        out_row,
  output logic [ROW_IDX_W-1:0]      out_row_idx,
  output logic                      out_last,
  output logic [1:0]                occupancy,
  output logic                      capture_dropped
);

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(N - 1);

  bank_state_e                r_bank_state     [2];
  bank_state_e                w_bank_state_nxt [2];
  logic [N-1:0][N-1:0][31:0]  r_bank           [2];
  logic                       r_wr_bank;
  logic                       r_rd_bank;
  logic [ROW_IDX_W-1:0]       r_row_idx;
  logic                       r_capture_dropped;

  logic [1:0]                 w_full;
  logic [1:0]                 w_wr_sel;
  logic [1:0]                 w_rd_sel;
  logic                       w_pop;
  logic                       w_last_row;
  logic                       w_release;
  logic                       w_wr_free;
  logic                       w_accept;
  logic [N-1:0][31:0]         w_raw_row;
  logic [N-1:0][31:0]         w_out_row;

  // Decode bank occupancy, handshake and capture acceptance
  always_comb begin
    w_full[0]  = (r_bank_state[0] == BANK_FULL);
    w_full[1]  = (r_bank_state[1] == BANK_FULL);
    w_wr_sel   = {r_wr_bank, ~r_wr_bank};
    w_rd_sel   = {r_rd_bank, ~r_rd_bank};
    w_pop      = out_valid & out_ready;
    w_last_row = (r_row_idx == LAST_ROW);
    w_release  = w_pop & w_last_row;
    // The write bank may be freed by the final-row pop in this very cycle.
    w_wr_free  = ~w_full[r_wr_bank] | (w_release & (r_rd_bank == r_wr_bank));
    w_accept   = capture & w_wr_free;
  end

  // Per-bank EMPTY/FULL next state; a refill in the release cycle keeps the bank full
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bank_state_nxt[b] = r_bank_state[b];
      case (r_bank_state[b])
        BANK_EMPTY: begin
          if (w_accept && w_wr_sel[b]) begin
            w_bank_state_nxt[b] = BANK_FULL;
          end
        end
        BANK_FULL: begin
          if (w_release && w_rd_sel[b] && !(w_accept && w_wr_sel[b])) begin
            w_bank_state_nxt[b] = BANK_EMPTY;
          end
        end
        default: w_bank_state_nxt[b] = BANK_EMPTY;
      endcase
    end
  end

  // Bank state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank_state[0] <= BANK_EMPTY;
      r_bank_state[1] <= BANK_EMPTY;
    end else begin
      r_bank_state[0] <= w_bank_state_nxt[0];
      r_bank_state[1] <= w_bank_state_nxt[1];
    end
  end

  // Bank pointers, row counter and sticky drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_bank         <= 1'b0;
      r_rd_bank         <= 1'b0;
      r_row_idx         <= '0;
      r_capture_dropped <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
        r_row_idx <= '0;
      end else if (w_pop) begin
        r_row_idx <= r_row_idx + ROW_IDX_W'(1);
      end
      if (capture && !w_accept) begin
        r_capture_dropped <= 1'b1;
      end
    end
  end

  // Snapshot storage; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      r_bank[r_wr_bank] <= C_in;
    end
  end

  // Read path: select the current row and optionally clamp negatives to zero
  always_comb begin
    w_raw_row = r_bank[r_rd_bank][r_row_idx];
    w_out_row = w_raw_row;
`ifdef SYSTOLIC_DRAIN_RELU_EN
    for (int c = 0; c < N; c++) begin
      if (w_raw_row[c][31]) begin
        w_out_row[c] = '0;
      end
    end
`else
    w_out_row = w_raw_row;
`endif
  end

  assign out_valid       = w_full[r_rd_bank];
  assign out_row         = w_out_row;
  assign out_row_idx     = r_row_idx;
  assign out_last        = out_valid & w_last_row;
  assign occupancy       = {1'b0, w_full[0]} + {1'b0, w_full[1]};
  assign capture_dropped = r_capture_dropped;

endmodule

// File: tb/tb_systolic_output_drain.sv
// tb/tb_systolic_output_drain.sv - randomized bench for systolic_output_drain against a tile-queue model
module tb_systolic_output_drain;
  localparam int N  = 8;
  localparam int RW = 3;

  typedef logic [N-1:0][N-1:0][31:0] tile_t;
  typedef logic [N-1:0][31:0]        row_t;
  typedef logic [N*32-1:0]           wide_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          capture;
  tile_t         C_in;
  logic          out_valid;
  logic          out_ready;
  row_t          out_row;
  logic [RW-1:0] out_row_idx;
  logic          out_last;
  logic [1:0]    occupancy;
  logic          capture_dropped;

  systolic_output_drain #(.N(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .capture        (capture),
    .C_in           (C_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_row        (out_row),
    .out_row_idx    (out_row_idx),
    .out_last       (out_last),
    .occupancy      (occupancy),
    .capture_dropped(capture_dropped)
  );

  always #5 clk = ~clk;

  // Reference: FIFO of captured tiles (at most two), row cursor into the oldest
  tile_t m_q[$];
  int    m_row     = 0;
  bit    m_dropped = 1'b0;

  int    n_cmp = 0;
  int    n_mis = 0;
  bit    prev_stall = 1'b0;
  row_t  prev_row;

  task automatic chk(input string tag, input wide_t got, input wide_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic row_t expect_row(input tile_t t, input int r);
    row_t v;
    v = t[r];
`ifdef SYSTOLIC_DRAIN_RELU_EN
    for (int c = 0; c < N; c++) begin
      if ($signed(v[c]) < 0) v[c] = '0;
    end
`endif
    return v;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        t[r][c] = $urandom;
    return t;
  endfunction

  task automatic model_step(input bit cap, input bit rdy, input bit rst, input tile_t d);
    bit pop, lastpop, acc;
    if (rst) begin
      m_q.delete();
      m_row     = 0;
      m_dropped = 1'b0;
      return;
    end
    pop     = (m_q.size() > 0) && rdy;
    lastpop = pop && (m_row == N - 1);
    acc     = cap && ((m_q.size() < 2) || lastpop);
    if (pop) begin
      if (lastpop) begin
        void'(m_q.pop_front());
        m_row = 0;
      end else begin
        m_row++;
      end
    end
    if (acc) m_q.push_back(d);
    else if (cap) m_dropped = 1'b1;
  endtask

  task automatic check_outputs();
    bit v;
    v = (m_q.size() > 0);
    chk("out_valid", wide_t'(out_valid), wide_t'(v));
    chk("occupancy", wide_t'(occupancy), wide_t'(m_q.size()));
    chk("capture_dropped", wide_t'(capture_dropped), wide_t'(m_dropped));
    chk("out_row_idx", wide_t'(out_row_idx), wide_t'(m_row));
    chk("out_last", wide_t'(out_last), wide_t'(v && (m_row == N - 1)));
    if (v) chk("out_row", wide_t'(out_row), wide_t'(expect_row(m_q[0], m_row)));
    if (prev_stall) chk("out_row_stable", wide_t'(out_row), wide_t'(prev_row));
  endtask

  task automatic cycle(input bit cap, input bit rdy, input bit rst, input tile_t d);
    capture    = cap;
    out_ready  = rdy;
    reset      = rst;
    C_in       = d;
    prev_stall = (out_valid === 1'b1) && !rdy && !rst;
    prev_row   = out_row;
    @(posedge clk);
    model_step(cap, rdy, rst, d);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    tile_t t;
    tile_t z;
    z = '0;

    // Reset state
    cycle(1'b0, 1'b0, 1'b1, z);
    cycle(1'b0, 1'b1, 1'b1, z);
    chk("reset_valid", wide_t'(out_valid), wide_t'(0));
    chk("reset_occ", wide_t'(occupancy), wide_t'(0));

    // Basic drain of a ramp
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        t[r][c] = 32'(r * 8 + c);
    cycle(1'b1, 1'b1, 1'b0, t);
    chk("basic_row0_idx", wide_t'(out_row_idx), wide_t'(0));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, rand_tile());
    chk("basic_occ_end", wide_t'(occupancy), wide_t'(0));

    // Back-pressure with random ready
    cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, rand_tile());
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, rand_tile());
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, rand_tile());

    // Double buffering, then a capture into two full banks
    cycle(1'b0, 1'b0, 1'b1, z);
    cycle(1'b1, 1'b1, 1'b0, rand_tile());
    cycle(1'b0, 1'b1, 1'b0, rand_tile());
    cycle(1'b1, 1'b1, 1'b0, rand_tile());
    chk("dbuf_occ2", wide_t'(occupancy), wide_t'(2));
    cycle(1'b1, 1'b1, 1'b0, rand_tile());
    chk("dbuf_dropped", wide_t'(capture_dropped), wide_t'(1));
    for (int i = 0; i < 18; i++) cycle(1'b0, 1'b1, 1'b0, rand_tile());

    // Release/capture collision on the final row of the oldest bank
    cycle(1'b0, 1'b0, 1'b1, z);
    cycle(1'b1, 1'b0, 1'b0, rand_tile());
    cycle(1'b1, 1'b0, 1'b0, rand_tile());
    for (int i = 0; i < N - 1; i++) cycle(1'b0, 1'b1, 1'b0, rand_tile());
    chk("coll_last_before", wide_t'(out_last), wide_t'(1));
    cycle(1'b1, 1'b1, 1'b0, rand_tile());
    chk("coll_occ", wide_t'(occupancy), wide_t'(2));
    chk("coll_dropped", wide_t'(capture_dropped), wide_t'(0));
    for (int i = 0; i < 2 * N + 2; i++) cycle(1'b0, 1'b1, 1'b0, rand_tile());

    // Reset mid-drain with a simultaneous capture and pop
    cycle(1'b1, 1'b1, 1'b0, rand_tile());
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, rand_tile());
    cycle(1'b1, 1'b1, 1'b1, rand_tile());
    chk("rst_mid_valid", wide_t'(out_valid), wide_t'(0));
    chk("rst_mid_occ", wide_t'(occupancy), wide_t'(0));
    chk("rst_mid_idx", wide_t'(out_row_idx), wide_t'(0));
    cycle(1'b1, 1'b1, 1'b0, rand_tile());
    chk("rst_restart_idx", wide_t'(out_row_idx), wide_t'(0));
    for (int i = 0; i < N + 2; i++) cycle(1'b0, 1'b1, 1'b0, rand_tile());

    // Signed edge values through the optional clamp
    t = rand_tile();
    t[0][0] = 32'hFFFF_FFFB;
    t[0][1] = 32'h0000_0000;
    t[0][2] = 32'h0000_0007;
    t[0][3] = 32'h8000_0000;
    cycle(1'b1, 1'b0, 1'b0, t);
`ifdef SYSTOLIC_DRAIN_RELU_EN
    chk("relu_m5", wide_t'(out_row[0]), wide_t'(0));
    chk("relu_min", wide_t'(out_row[3]), wide_t'(0));
`else
    chk("pass_m5", wide_t'(out_row[0]), wide_t'(32'hFFFF_FFFB));
    chk("pass_min", wide_t'(out_row[3]), wide_t'(32'h8000_0000));
`endif
    chk("clamp_7", wide_t'(out_row[2]), wide_t'(7));
    for (int i = 0; i < N + 2; i++) cycle(1'b0, 1'b1, 1'b0, rand_tile());

    // Long random run with occasional reset
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 4) == 0, ($urandom % 3) != 0, ($urandom % 500) == 0, rand_tile());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
